game_tick_controller: RTL and testbench



---
 rtl/game_tick_controller_pkg.sv | 31 +++
 rtl/game_tick_controller_divider.sv | 36 +++
 rtl/game_tick_controller.sv | 143 ++++++++++++++
 tb/tb_game_tick_controller.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/game_tick_controller_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : game_tick_controller_pkg
// Description : State encoding, default timing constants and helpers shared by
//               the game tick controller and its divider.
// Revision    : 1.0 - initial release
// ============================================================================
package game_tick_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CRASH = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int unsigned c_SLOW_DIV   = 1_000_000;
    localparam int unsigned c_FAST_DIV   = 250_000;
    localparam int unsigned c_CRASH_HOLD = 60;
    localparam int unsigned c_LIVES      = 3;
    localparam int unsigned c_GRACE      = 2;

    localparam logic [15:0] c_SCORE_MAX  = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == c_SCORE_MAX) ? v : v + 16'd1;
    endfunction

endpackage : game_tick_controller_pkg
`default_nettype wire

// File: rtl/game_tick_controller_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tick_divider
// Description : Free-running 0..DIV-1 counter; tick is high while at DIV-1.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_divider #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned c_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [c_W-1:0] c_LAST = c_W'(DIV - 1);

    logic [c_W-1:0] r_cnt;
    logic           w_at_last;

    assign w_at_last = (r_cnt == c_LAST);
    assign tick      = w_at_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_at_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule : tick_divider
`default_nettype wire

// File: rtl/game_tick_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : game_tick_controller
// Description : Game sequencer: update/animation pulses, lives, score, crash
//               freeze and game-over handling.
// Revision    : 1.0 - initial release
// ============================================================================
module game_tick_controller
    import game_tick_controller_pkg::*;
#(
    parameter int unsigned SLOW_DIV   = c_SLOW_DIV,
    parameter int unsigned FAST_DIV   = c_FAST_DIV,
    parameter int unsigned CRASH_HOLD = c_CRASH_HOLD,
    parameter int unsigned LIVES      = c_LIVES,
    parameter int unsigned GRACE      = c_GRACE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        colision,
    output logic        upsig,
    output logic        upsig_fast,
    output logic        game_reset,
    output logic [1:0]  state,
    output logic [1:0]  lives,
    output logic [15:0] score,
    output logic        game_over
);

    localparam int unsigned c_HW = (CRASH_HOLD > 0) ? $clog2(CRASH_HOLD + 1) : 1;
    localparam int unsigned c_GW = (GRACE > 0) ? $clog2(GRACE + 1) : 1;
    localparam logic [c_HW-1:0] c_HOLD_LOAD  = c_HW'(CRASH_HOLD);
    localparam logic [c_GW-1:0] c_GRACE_LOAD = c_GW'(GRACE);
    localparam logic [1:0]      c_LIVES_LOAD = 2'(LIVES);

    state_t          r_state;
    logic            r_start_q;
    logic [1:0]      r_lives;
    logic [15:0]     r_score;
    logic [c_GW-1:0] r_grace;
    logic [c_HW-1:0] r_hold;
    logic            r_upsig;
    logic            r_upsig_fast;
    logic            r_game_reset;
    logic            r_game_over;

    logic w_slow_tick;
    logic w_fast_tick;
    logic w_start_edge;
    logic w_crash;

    tick_divider #(.DIV(SLOW_DIV)) u_slow_div (
        .clk   (clk),
        .reset (reset),
        .tick  (w_slow_tick)
    );

    tick_divider #(.DIV(FAST_DIV)) u_fast_div (
        .clk   (clk),
        .reset (reset),
        .tick  (w_fast_tick)
    );

    assign w_start_edge = start & ~r_start_q;
    // lives check keeps the counter from wrapping even if RUN were reached oddly
    assign w_crash      = colision && (r_grace == '0) && (r_lives != 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_start_q    <= 1'b0;
            r_lives      <= 2'd0;
            r_score      <= 16'd0;
            r_grace      <= '0;
            r_hold       <= '0;
            r_upsig      <= 1'b0;
            r_upsig_fast <= 1'b0;
            r_game_reset <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_start_q    <= start;
            r_upsig      <= 1'b0;
            r_game_reset <= 1'b0;
            r_upsig_fast <= w_fast_tick && (r_state == ST_RUN);

            case (r_state)
                ST_IDLE, ST_OVER: begin
                    if (w_start_edge) begin
                        r_state      <= ST_RUN;
                        r_lives      <= c_LIVES_LOAD;
                        r_score      <= 16'd0;
                        r_grace      <= c_GRACE_LOAD;
                        r_game_reset <= 1'b1;
                        r_game_over  <= 1'b0;
                    end
                end

                ST_RUN: begin
                    // a crash swallows the update pulse of the same cycle
                    if (w_crash) begin
                        r_state <= ST_CRASH;
                        r_lives <= r_lives - 2'd1;
                        r_hold  <= c_HOLD_LOAD;
                    end else if (w_slow_tick) begin
                        r_upsig <= 1'b1;
                        r_score <= sat_inc16(r_score);
                        if (r_grace != '0) begin
                            r_grace <= r_grace - 1'b1;
                        end
                    end
                end

                ST_CRASH: begin
                    if (r_hold == '0) begin
                        if (r_lives == 2'd0) begin
                            r_state     <= ST_OVER;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state      <= ST_RUN;
                            r_grace      <= c_GRACE_LOAD;
                            r_game_reset <= 1'b1;
                        end
                    end else if (w_slow_tick) begin
                        r_hold <= r_hold - 1'b1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign upsig      = r_upsig;
    assign upsig_fast = r_upsig_fast;
    assign game_reset = r_game_reset;
    assign state      = r_state;
    assign lives      = r_lives;
    assign score      = r_score;
    assign game_over  = r_game_over;

endmodule : game_tick_controller
`default_nettype wire

// File: tb/tb_game_tick_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_game_tick_controller
// Description : Directed bench with an upsig/score scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_tick_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        colision;
    logic        upsig;
    logic        upsig_fast;
    logic        game_reset;
    logic [1:0]  state;
    logic [1:0]  lives;
    logic [15:0] score;
    logic        game_over;

    int checks = 0;
    int errors = 0;
    int n_up   = 0;
    int n_fast = 0;
    int n_gr   = 0;
    logic [15:0] exp_q[$];

    game_tick_controller #(
        .SLOW_DIV   (8),
        .FAST_DIV   (2),
        .CRASH_HOLD (3),
        .LIVES      (2),
        .GRACE      (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .colision   (colision),
        .upsig      (upsig),
        .upsig_fast (upsig_fast),
        .game_reset (game_reset),
        .state      (state),
        .lives      (lives),
        .score      (score),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1ns after the edge, upsig events scored here.
    task automatic step();
        logic [15:0] e;
        @(posedge clk);
        #1;
        if (upsig === 1'b1) begin
            n_up++;
            check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_score", 32'(score), 32'(e));
            end
        end
        if (upsig_fast === 1'b1) n_fast++;
        if (game_reset === 1'b1) n_gr++;
    endtask

    initial begin
        int n;
        int b_up, b_fast, b_gr;

        reset = 1'b1; start = 1'b0; colision = 1'b0;
        repeat (3) step();
        check("rst_state", 32'(state), 32'd0);
        check("rst_lives", 32'(lives), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_pulses", {29'd0, upsig, upsig_fast, game_reset}, 32'd0);
        check("rst_game_over", 32'(game_over), 32'd0);

        // start held high: one edge, one game_reset, steady pulse trains
        reset = 1'b0; start = 1'b1;
        b_up = n_up; b_fast = n_fast; b_gr = n_gr;
        for (int i = 1; i <= 6; i++) exp_q.push_back(16'(i));
        repeat (50) step();
        check("start_game_reset_cnt", 32'(n_gr - b_gr), 32'd1);
        check("start_upsig_cnt", 32'(n_up - b_up), 32'd6);
        check("start_fast_cnt", 32'(n_fast - b_fast), 32'd25);
        check("start_state", 32'(state), 32'd1);
        check("start_lives", 32'(lives), 32'd2);
        check("start_score", 32'(score), 32'd6);
        check("start_sb_empty", 32'(exp_q.size()), 32'd0);

        // collision coincident with the slow tick: crash wins
        repeat (5) step();
        colision = 1'b1;
        step();
        colision = 1'b0;
        check("coinc_state", 32'(state), 32'd2);
        check("coinc_lives", 32'(lives), 32'd1);
        check("coinc_upsig", 32'(upsig), 32'd0);
        check("coinc_score", 32'(score), 32'd6);

        b_up = n_up; b_fast = n_fast; b_gr = n_gr;
        start = 1'b0; step();
        start = 1'b1; step();
        n = 2;
        while (state !== 2'd1 && n < 60) begin
            step();
            n++;
        end
        check("crash_resume_state", 32'(state), 32'd1);
        check("crash_len", 32'(n >= 24 && n <= 25), 32'd1);
        check("crash_no_upsig", 32'(n_up - b_up), 32'd0);
        check("crash_no_fast", 32'(n_fast - b_fast), 32'd0);
        check("crash_game_reset_cnt", 32'(n_gr - b_gr), 32'd1);
        check("crash_resume_pulse", 32'(game_reset), 32'd1);

        // collision during grace is ignored
        colision = 1'b1;
        repeat (5) step();
        colision = 1'b0;
        check("grace_state", 32'(state), 32'd1);
        check("grace_lives", 32'(lives), 32'd1);
        exp_q.push_back(16'd7);
        repeat (4) step();
        check("grace_sb_empty", 32'(exp_q.size()), 32'd0);

        // second accepted collision ends the game
        colision = 1'b1;
        step();
        colision = 1'b0;
        check("crash2_state", 32'(state), 32'd2);
        check("crash2_lives", 32'(lives), 32'd0);
        b_gr = n_gr;
        n = 0;
        while (state !== 2'd3 && n < 60) begin
            step();
            n++;
        end
        check("over_state", 32'(state), 32'd3);
        check("over_flag", 32'(game_over), 32'd1);
        repeat (5) step();
        check("over_score_frozen", 32'(score), 32'd7);
        check("over_lives", 32'(lives), 32'd0);
        check("over_no_game_reset", 32'(n_gr - b_gr), 32'd0);

        // restart from OVER
        start = 1'b0; step();
        start = 1'b1; step();
        check("restart_state", 32'(state), 32'd1);
        check("restart_lives", 32'(lives), 32'd2);
        check("restart_score", 32'(score), 32'd0);
        check("restart_game_reset", 32'(game_reset), 32'd1);
        check("restart_game_over", 32'(game_over), 32'd0);

        // score saturation
        force dut.r_score = 16'hFFFE;
        step();
        release dut.r_score;
        repeat (3) exp_q.push_back(16'hFFFF);
        b_up = n_up;
        n = 0;
        while ((n_up - b_up) < 3 && n < 40) begin
            step();
            n++;
        end
        check("sat_upsig_cnt", 32'(n_up - b_up), 32'd3);
        check("sat_score", 32'(score), 32'hFFFF);
        check("sat_sb_empty", 32'(exp_q.size()), 32'd0);

        // reset while crashed
        colision = 1'b1;
        n = 0;
        while (state !== 2'd2 && n < 20) begin
            step();
            n++;
        end
        colision = 1'b0;
        check("pre_reset_crash", 32'(state), 32'd2);
        step();
        reset = 1'b1; start = 1'b0;
        step();
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_lives", 32'(lives), 32'd0);
        check("mid_rst_score", 32'(score), 32'd0);
        check("mid_rst_pulses", {29'd0, upsig, upsig_fast, game_reset}, 32'd0);
        check("mid_rst_game_over", 32'(game_over), 32'd0);
        reset = 1'b0;
        b_up = n_up; b_gr = n_gr;
        repeat (20) step();
        check("post_rst_idle", 32'(state), 32'd0);
        check("post_rst_no_game_reset", 32'(n_gr - b_gr), 32'd0);
        check("post_rst_no_upsig", 32'(n_up - b_up), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_game_tick_controller
`default_nettype wire
